// File: rtl/spike_emitter_pkg.sv
// ---------------------------------------------------------------------------
// spike_emitter_pkg
//   Shared definitions for the spike emitter and its companion timer:
//   FSM state encoding and the default Delay width, spike width and
//   refractory length.
//   No ports (package).
// ---------------------------------------------------------------------------
package spike_emitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_FIRE    = 2'd2,
    ST_REFRACT = 2'd3
  } state_e;

  localparam int DEF_DW          = 32;
  localparam int DEF_SPIKE_WIDTH = 1;
  localparam int DEF_REFRACT     = 4;

endpackage

// File: rtl/spike_emitter_if.sv
// ---------------------------------------------------------------------------
// spike_emitter_if
//   Request/response bundle between a spike requester and spike_emitter.
//   Signals:
//     Load      requester -> emitter  start a countdown with Delay
//     Delay     requester -> emitter  cycles from acceptance to Spike, minus 1
//     Cancel    requester -> emitter  abort countdown / spike / refractory
//     Ready     emitter -> requester  a Load is accepted this cycle
//     Spike     emitter -> requester  output spike
//     Busy      emitter -> requester  emitter not idle
//     Remaining emitter -> requester  cycles left before Spike rises
//   Modports: master (requester side), slave (emitter side).
// ---------------------------------------------------------------------------
interface spike_emitter_if
  import spike_emitter_pkg::*;
#(
  parameter int DW = DEF_DW
);

  logic          Load;
  logic [DW-1:0] Delay;
  logic          Cancel;
  logic          Ready;
  logic          Spike;
  logic          Busy;
  logic [DW-1:0] Remaining;

  modport master (
    output Load, Delay, Cancel,
    input  Ready, Spike, Busy, Remaining
  );

  modport slave (
    input  Load, Delay, Cancel,
    output Ready, Spike, Busy, Remaining
  );

endinterface

// File: rtl/spike_emitter_down_counter.sv
// ---------------------------------------------------------------------------
// spike_emitter_down_counter
//   Loadable DW-bit down-counter with zero flag. Decrements only while
//   non-zero, so it never wraps. Load has priority over decrement.
//   Ports:
//     i_clk        clock, rising edge
//     i_rst        synchronous active-high reset (count -> 0)
//     i_load       load i_load_val on the next edge
//     i_load_val   value to load
//     i_dec        decrement on the next edge (ignored at zero)
//     o_count_next value the counter takes on the next edge
//     o_zero       current count is zero
// ---------------------------------------------------------------------------
module spike_emitter_down_counter #(
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_load_val,
  input  logic          i_dec,
  output logic [DW-1:0] o_count_next,
  output logic          o_zero
);

  logic [DW-1:0] r_count;

  always_comb begin
    o_count_next = r_count;
    if (i_load) begin
      o_count_next = i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      o_count_next = r_count - DW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= o_count_next;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/spike_emitter.sv
// ---------------------------------------------------------------------------
// spike_emitter
//   Turns a cycle delay into a timed spike. A Load accepted at edge t with
//   Delay D drives Spike high on edges t+D+1 .. t+D+SPIKE_WIDTH, then holds
//   a refractory gap of REFRACT cycles before returning to idle.
//   All outputs are registered.
//
//   Parameters:
//     DW          width of Delay / Remaining
//     SPIKE_WIDTH cycles Spike stays high per fire (>= 1)
//     REFRACT     low cycles after a spike before Ready returns (>= 0)
//
//   Ports:
//     Clk    clock, rising edge
//     Reset  synchronous active-high reset
//     bus    spike_emitter_if.slave (Load/Delay/Cancel in,
//            Ready/Spike/Busy/Remaining out)
//
//   Build option:
//     SPIKE_EMITTER_QUEUE_EN  adds a one-entry pending buffer so a second
//                             request can be accepted while busy and starts
//                             straight after the current refractory period.
// ---------------------------------------------------------------------------
module spike_emitter
  import spike_emitter_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int SPIKE_WIDTH = DEF_SPIKE_WIDTH,
  parameter int REFRACT     = DEF_REFRACT
) (
  input  logic           Clk,
  input  logic           Reset,
  spike_emitter_if.slave bus
);

`ifdef SPIKE_EMITTER_QUEUE_EN
  localparam bit QUEUE_EN = 1'b1;
`else
  localparam bit QUEUE_EN = 1'b0;
`endif

  // One counter serves all three timed states; each state loads its length
  // minus one and leaves on the edge where the count is already zero.
  localparam logic [DW-1:0] FIRE_LEN    = DW'(SPIKE_WIDTH - 1);
  localparam logic [DW-1:0] REFR_LEN    = DW'((REFRACT > 0) ? (REFRACT - 1) : 0);
  localparam bit            HAS_REFRACT = (REFRACT > 0);

  state_e        r_state;
  state_e        w_state_next;
  logic          r_ready;
  logic          r_spike;
  logic          r_busy;
  logic [DW-1:0] r_remaining;
  logic          r_pend_vld;
  logic [DW-1:0] r_pend_delay;

  logic          w_accept;
  logic          w_exit;
  logic          w_pend_set;
  logic          w_pend_clr;
  logic          w_pend_vld_next;
  logic          w_cnt_load;
  logic          w_cnt_dec;
  logic          w_cnt_zero;
  logic [DW-1:0] w_cnt_val;
  logic [DW-1:0] w_cnt_next;

  spike_emitter_down_counter #(
    .DW (DW)
  ) u_cnt (
    .i_clk        (Clk),
    .i_rst        (Reset),
    .i_load       (w_cnt_load),
    .i_load_val   (w_cnt_val),
    .i_dec        (w_cnt_dec),
    .o_count_next (w_cnt_next),
    .o_zero       (w_cnt_zero)
  );

  always_comb begin
    // Cancel blocks acceptance even when Ready is high.
    w_accept     = bus.Load && r_ready && !bus.Cancel;
    w_state_next = r_state;
    w_exit       = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_val    = '0;
    w_cnt_dec    = 1'b0;
    w_pend_set   = 1'b0;
    w_pend_clr   = 1'b0;

    if (bus.Cancel) begin
      w_pend_clr = 1'b1;
      if (r_state != ST_IDLE) begin
        w_state_next = ST_IDLE;
        w_cnt_load   = 1'b1;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_state_next = ST_WAIT;
            w_cnt_load   = 1'b1;
            w_cnt_val    = bus.Delay;
          end
        end
        ST_WAIT: begin
          w_pend_set = w_accept;
          if (w_cnt_zero) begin
            w_state_next = ST_FIRE;
            w_cnt_load   = 1'b1;
            w_cnt_val    = FIRE_LEN;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        ST_FIRE: begin
          w_pend_set = w_accept;
          if (!w_cnt_zero) begin
            w_cnt_dec = 1'b1;
          end else if (HAS_REFRACT) begin
            w_state_next = ST_REFRACT;
            w_cnt_load   = 1'b1;
            w_cnt_val    = REFR_LEN;
          end else begin
            w_exit = 1'b1;
          end
        end
        ST_REFRACT: begin
          w_pend_set = w_accept;
          if (w_cnt_zero) begin
            w_exit = 1'b1;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        default: ;
      endcase

      // End of a spike cycle: a buffered request (or one arriving on this
      // very edge) restarts the countdown without passing through IDLE.
      if (w_exit) begin
        w_pend_set = 1'b0;
        w_cnt_load = 1'b1;
        if (r_pend_vld) begin
          w_state_next = ST_WAIT;
          w_cnt_val    = r_pend_delay;
          w_pend_clr   = 1'b1;
        end else if (w_accept) begin
          w_state_next = ST_WAIT;
          w_cnt_val    = bus.Delay;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
    end

    w_pend_vld_next = QUEUE_EN && ((r_pend_vld && !w_pend_clr) || w_pend_set);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_spike     <= 1'b0;
      r_busy      <= 1'b0;
      r_remaining <= '0;
      r_pend_vld  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ready     <= (w_state_next == ST_IDLE) || (QUEUE_EN && !w_pend_vld_next);
      r_spike     <= (w_state_next == ST_FIRE);
      r_busy      <= (w_state_next != ST_IDLE);
      r_remaining <= (w_state_next == ST_WAIT) ? w_cnt_next : '0;
      r_pend_vld  <= w_pend_vld_next;
      if (w_pend_set) begin
        r_pend_delay <= bus.Delay;
      end
    end
  end

  assign bus.Ready     = r_ready;
  assign bus.Spike     = r_spike;
  assign bus.Busy      = r_busy;
  assign bus.Remaining = r_remaining;

endmodule
